rd_fwft_ctrl: RTL and testbench
===============================

RD_FWFT_CTRL -- requirements
Module: rd_fwft_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, FIFO memory depth 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, word width.
REQ-003 SHALL have parameter AEMPTY_TH, default 2, almost-empty threshold in memory entries.
REQ-004 RCLK  in  1  read-domain clock; all state on rising edge.
REQ-005 RRSTn  in  1  reset, asynchronous, active-low.
REQ-006 wp2_rpt  in  ADDR_WIDTH+1  write pointer, gray, already synchronized into RCLK domain.
REQ-007 rd_en  in  1  consumer pop request; a pop occurs when rd_en and dout_valid are both high.
REQ-008 mem_rdata  in  DATA_WIDTH  memory read data, valid exactly one RCLK after mem_ren.
REQ-009 mem_ren  out  1  memory read strobe, combinational.
REQ-010 raddr  out  ADDR_WIDTH  memory read address, equal to rbin[ADDR_WIDTH-1:0].
REQ-011 rpt  out  ADDR_WIDTH+1  registered gray read pointer, sent to the write-domain synchronizer.
REQ-012 dout  out  DATA_WIDTH  first-word-fall-through head data.
REQ-013 dout_valid  out  1  dout holds a valid word.
REQ-014 rempty  out  1  equals !dout_valid.
REQ-015 rlevel  out  ADDR_WIDTH+1  unread memory entries (see Configuration).
REQ-016 ralmost_empty  out  1  rlevel <= AEMPTY_TH (see Configuration).

Function
REQ-017 SHALL keep binary read pointer rbin (ADDR_WIDTH+1 bits) and rpt = bin2gray(rbin), both registered, wrapping modulo 2**(ADDR_WIDTH+1).
REQ-018 SHALL define mem_empty = (rpt == wp2_rpt), combinational.
REQ-019 SHALL hold a 2-entry output buffer (head register plus skid register) and a pending flag marking a read in flight.
REQ-020 Occupancy FSM states: EMPTY (0 words), ONE (head only), TWO (head and skid); skid never valid without head.
REQ-021 SHALL assert mem_ren iff !mem_empty and (occupancy + pending - pop) < 2, evaluated in the current cycle.
REQ-022 On mem_ren SHALL increment rbin and update rpt in the same edge; pending set on next edge, cleared the edge after unless re-issued.
REQ-023 Arriving word (pending high) SHALL load head if head empty or head popped this cycle with skid empty, else load skid.
REQ-024 On pop with skid valid SHALL move skid to head in the same edge; simultaneous arrival then loads skid.
REQ-025 Sustained rd_en with non-empty memory SHALL give one pop per cycle, no bubbles.
REQ-026 First-word latency: wp2_rpt change visible at cycle N gives mem_ren at N, dout_valid at N+2.
REQ-027 Pop while dout_valid low SHALL be ignored; dout SHALL hold its value when not popped.
REQ-028 Word order at dout SHALL equal memory address order across the pointer wrap 2**(ADDR_WIDTH+1)-1 -> 0.

Reset
REQ-029 RRSTn low SHALL asynchronously clear rbin, rpt, pending, head, skid, dout to 0, FSM to EMPTY, dout_valid to 0, rempty to 1.
REQ-030 Reset mid-operation SHALL discard in-flight and buffered words; first post-reset mem_ren reads address 0.

Configuration
REQ-031 Macro RD_LEVEL_EN: when defined, rlevel = gray2bin(wp2_rpt) - rbin (modulo 2**(ADDR_WIDTH+1)), registered, reset 0, and ralmost_empty registered from it, reset 1.
REQ-032 Without RD_LEVEL_EN, rlevel SHALL be tied to 0, ralmost_empty tied to rempty, no gray-to-binary logic synthesized.

Structure
REQ-033 Shared package fifo_pkg SHALL hold bin2gray and gray2bin functions and the FSM state enum (EMPTY, ONE, TWO).
REQ-034 The 2-entry head/skid buffer SHALL be one sub-module, fwft_skid; pointer and mem_ren logic stay in the top.

Verification
REQ-035 Reset, wp2_rpt=0 -> mem_ren=0, rpt=0, dout_valid=0, rempty=1, rlevel=0.
REQ-036 wp2_rpt=gray(1), rd_en=0 -> mem_ren at N, raddr=0, rpt=gray(1) at N+1, dout_valid=1 at N+2, dout=mem[0].
REQ-037 wp2_rpt=gray(8), rd_en=0 -> exactly two reads issued, FSM TWO, mem_ren stays 0; then rd_en=1 -> 8 words in order, one per cycle.
REQ-038 rbin at 30, wp2_rpt=gray(2), continuous rd_en -> raddr 14,15,0,1, rpt wraps 31->0, words in order.
REQ-039 Reset asserted with pending=1 and FSM TWO -> dout_valid=0 immediately, next read at raddr=0.
REQ-040 With RD_LEVEL_EN, wp2_rpt=gray(5), rbin=3 -> rlevel=2, ralmost_empty=1; without macro rlevel=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: gray/binary pointer conversion and the read-side
// output-buffer occupancy state.
package fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended inputs decode correctly because leading zero gray bits stay zero.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fwft_skid.sv
// Two-entry head/skid output buffer for the FWFT read port.
// A word arriving while head is held and not popped parks in skid.
module fwft_skid
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  RCLK,
  input  logic                  RRSTn,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_dat,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic [1:0]            occ
);

  occ_state_t            state, state_nxt;
  logic [DATA_WIDTH-1:0] head, skid;
  logic                  head_ld_in, head_ld_skid, skid_ld;

  always_ff @(posedge RCLK or negedge RRSTn) begin
    if (!RRSTn) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (in_vld) state_nxt = ONE;
      ONE: begin
        if (in_vld && !pop)      state_nxt = TWO;
        else if (!in_vld && pop) state_nxt = EMPTY;
      end
      TWO:     if (pop && !in_vld) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // The read strobe upstream never lets a word arrive into a full, unpopped buffer.
  always_comb begin
    dout_valid   = (state != EMPTY);
    occ          = state;
    head_ld_in   = in_vld && ((state == EMPTY) || (state == ONE && pop));
    head_ld_skid = pop && (state == TWO);
    skid_ld      = in_vld && ((state == ONE && !pop) || (state == TWO && pop));
  end

  always_ff @(posedge RCLK or negedge RRSTn) begin
    if (!RRSTn) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (head_ld_in)        head <= in_dat;
      else if (head_ld_skid) head <= skid;
      if (skid_ld)           skid <= in_dat;
    end
  end

  assign dout = head;

endmodule

// File: rtl/rd_fwft_ctrl.sv
// Async-FIFO read-side controller with first-word-fall-through output.
// Optional registered level / almost-empty outputs under macro RD_LEVEL_EN.
module rd_fwft_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                  RCLK,
  input  logic                  RRSTn,
  input  logic [ADDR_WIDTH:0]   wp2_rpt,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rpt,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  rempty,
  output logic [ADDR_WIDTH:0]   rlevel,
  output logic                  ralmost_empty
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] rbin, rbin_nxt;
  logic          pending, mem_empty, pop;
  logic [1:0]    occ;
  logic [2:0]    demand;

  assign pop       = rd_en && dout_valid;
  assign mem_empty = (rpt == wp2_rpt);
  // Words buffered or in flight after this cycle's pop; keep at most two.
  assign demand    = {1'b0, occ} + {2'b00, pending} - {2'b00, pop};
  assign mem_ren   = !mem_empty && (demand < 3'd2);
  assign rbin_nxt  = rbin + PW'(1);
  assign raddr     = rbin[ADDR_WIDTH-1:0];
  assign rempty    = !dout_valid;

  always_ff @(posedge RCLK or negedge RRSTn) begin
    if (!RRSTn) begin
      rbin    <= '0;
      rpt     <= '0;
      pending <= 1'b0;
    end else begin
      pending <= mem_ren;
      if (mem_ren) begin
        rbin <= rbin_nxt;
        rpt  <= PW'(bin2gray(32'(rbin_nxt)));
      end
    end
  end

  fwft_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .RCLK       (RCLK),
    .RRSTn      (RRSTn),
    .in_vld     (pending),
    .in_dat     (mem_rdata),
    .pop        (pop),
    .dout       (dout),
    .dout_valid (dout_valid),
    .occ        (occ)
  );

`ifdef RD_LEVEL_EN
  localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_TH);

  logic [PW-1:0] wbin, level_nxt;

  assign wbin      = PW'(gray2bin(32'(wp2_rpt)));
  assign level_nxt = wbin - rbin;

  always_ff @(posedge RCLK or negedge RRSTn) begin
    if (!RRSTn) begin
      rlevel        <= '0;
      ralmost_empty <= 1'b1;
    end else begin
      rlevel        <= level_nxt;
      ralmost_empty <= (level_nxt <= AE_TH);
    end
  end
`else
  assign rlevel        = '0;
  assign ralmost_empty = rempty;
`endif

endmodule

// File: tb/tb_rd_fwft_ctrl.sv
// Directed bench for rd_fwft_ctrl: a word-count model predicts every output each
// cycle, plus literal checks on reset, first-word latency, wrap and mid-run reset.
module tb_rd_fwft_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int PW = AW + 1;

  logic          RCLK = 1'b0;
  logic          RRSTn = 1'b0;
  logic [PW-1:0] wp2_rpt = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ren;
  logic [AW-1:0] raddr;
  logic [PW-1:0] rpt;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          rempty;
  logic [PW-1:0] rlevel;
  logic          ralmost_empty;

  rd_fwft_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AEMPTY_TH(2)) dut (
    .RCLK(RCLK), .RRSTn(RRSTn), .wp2_rpt(wp2_rpt), .rd_en(rd_en),
    .mem_rdata(mem_rdata), .mem_ren(mem_ren), .raddr(raddr), .rpt(rpt),
    .dout(dout), .dout_valid(dout_valid), .rempty(rempty),
    .rlevel(rlevel), .ralmost_empty(ralmost_empty)
  );

  always #5 RCLK = ~RCLK;

  logic [DW-1:0] mem [16];
  always @(posedge RCLK) if (mem_ren) mem_rdata <= mem[raddr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] gray(input int b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Model: words fetched (rd_cnt), words consumed (pop_cnt), one fetch in flight (pend).
  int            rd_cnt, pop_cnt;
  bit            pend;
  logic [PW-1:0] exp_lvl;
  bit            exp_ae;

  function automatic bit m_valid();
    return (rd_cnt - pop_cnt - int'(pend)) > 0;
  endfunction

  function automatic bit m_ren();
    int p;
    p = (rd_en && m_valid()) ? 1 : 0;
    return (gray(rd_cnt) != wp2_rpt) && ((rd_cnt - pop_cnt - p) < 2);
  endfunction

  always @(posedge RCLK or negedge RRSTn) begin
    if (!RRSTn) begin
      rd_cnt = 0; pop_cnt = 0; pend = 0; exp_lvl = '0; exp_ae = 1;
    end else begin
      bit r, p;
      r = m_ren();
      p = rd_en && m_valid();
`ifdef RD_LEVEL_EN
      exp_lvl = g2b(wp2_rpt) - PW'(rd_cnt);
      exp_ae  = (exp_lvl <= PW'(2));
`endif
      rd_cnt  += int'(r);
      pop_cnt += int'(p);
      pend    = r;
    end
  end

  always @(negedge RCLK) begin
    if (RRSTn) begin
      chk("mem_ren", mem_ren, m_ren());
      chk("raddr", raddr, rd_cnt % 16);
      chk("rpt", rpt, gray(rd_cnt));
      chk("dout_valid", dout_valid, m_valid());
      chk("rempty", rempty, !m_valid());
      if (m_valid()) chk("dout", dout, mem[pop_cnt % 16]);
`ifdef RD_LEVEL_EN
      chk("rlevel", rlevel, exp_lvl);
      chk("ralmost_empty", ralmost_empty, exp_ae);
`else
      chk("rlevel", rlevel, 0);
      chk("ralmost_empty", ralmost_empty, !m_valid());
`endif
    end
  end

  task automatic drive_edge();
    @(posedge RCLK);
    #1;
  endtask

  initial begin
    int n, first8, got;
    int addrs [4];
    for (int i = 0; i < 16; i++) mem[i] = DW'(8'hA0 + i);

    // Reset values
    #12;
    chk("rst_mem_ren", mem_ren, 0);
    chk("rst_rpt", rpt, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_rempty", rempty, 1);
    chk("rst_rlevel", rlevel, 0);
    @(negedge RCLK); #2 RRSTn = 1'b1;
    repeat (3) drive_edge();

    // First-word latency
    wp2_rpt = gray(1);
    @(negedge RCLK);
    chk("lat_ren_N", mem_ren, 1);
    chk("lat_raddr_N", raddr, 0);
    @(negedge RCLK);
    chk("lat_rpt_N1", rpt, 5'd1);
    chk("lat_valid_N1", dout_valid, 0);
    @(negedge RCLK);
    chk("lat_valid_N2", dout_valid, 1);
    chk("lat_dout_N2", dout, 8'hA0);
    drive_edge(); rd_en = 1'b1;
    drive_edge(); rd_en = 1'b0;
    @(negedge RCLK);
    chk("pop_empty", rempty, 1);

    // Fill the two-word buffer, then stream eight words
    drive_edge(); RRSTn = 1'b0; #3 RRSTn = 1'b1; wp2_rpt = gray(8);
    n = 0;
    repeat (8) begin @(negedge RCLK); if (mem_ren) n++; end
    chk("fill_reads", n, 2);
    chk("fill_valid", dout_valid, 1);
    drive_edge(); rd_en = 1'b1;
    n = 0; first8 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge RCLK);
      if (rd_en && dout_valid) begin n++; if (c < 8) first8++; end
    end
    chk("stream_pops", n, 8);
    chk("stream_nobubble", first8, 8);

    // Advance to rbin=30, then read across the pointer wrap
    drive_edge(); wp2_rpt = gray(16);
    repeat (12) drive_edge(); wp2_rpt = gray(24);
    repeat (12) drive_edge(); wp2_rpt = gray(30);
    repeat (12) drive_edge();
    chk("pre_wrap_rpt", rpt, gray(30));
    wp2_rpt = gray(34);
    n = 0;
    repeat (10) begin
      @(negedge RCLK);
      if (mem_ren) begin if (n < 4) addrs[n] = int'(raddr); n++; end
    end
    chk("wrap_reads", n, 4);
    chk("wrap_a0", addrs[0], 14);
    chk("wrap_a1", addrs[1], 15);
    chk("wrap_a2", addrs[2], 0);
    chk("wrap_a3", addrs[3], 1);
    chk("wrap_rpt", rpt, 5'd3);
    chk("wrap_drained", dout_valid, 0);

    // Reset during streaming discards everything buffered or in flight
    drive_edge(); wp2_rpt = gray(44);
    repeat (3) drive_edge();
    #1 RRSTn = 1'b0;
    #1;
    chk("mid_rst_valid", dout_valid, 0);
    chk("mid_rst_rempty", rempty, 1);
    chk("mid_rst_rpt", rpt, 0);
    rd_en = 1'b0; wp2_rpt = gray(5);
    #1 RRSTn = 1'b1;
    got = 0;
    for (int c = 0; c < 5 && got == 0; c++) begin
      @(negedge RCLK);
      if (mem_ren) begin got = 1; chk("post_rst_raddr", raddr, 0); end
    end
    if (got == 0) begin
      errors++;
      $display("FAIL post_rst_ren: got no mem_ren, expected one within 5 cycles");
    end
    repeat (5) @(negedge RCLK);
    chk("post_rst_dout", dout, 8'hA0);
`ifdef RD_LEVEL_EN
    chk("lvl_value", rlevel, 3);
    chk("lvl_ae", ralmost_empty, 0);
`else
    chk("lvl_value", rlevel, 0);
    chk("lvl_ae", ralmost_empty, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
